draw_sequencer: RTL and testbench

Frame-level controller for the single VGA plot port. It watches the board state (grid plus decoded score digits) and a manual redraw request. On any change it freezes a snapshot, optionally clears the screen, then releases the board painter from reset and forwards its pixel stream to the VGA adapter for a fixed number of cycles. It sits between game logic and the board painter / VGA adapter pair, and it is the only block that drives the adapter's plot enable.

---
 rtl/draw_sequencer.sv | 173 +++++++++++++++++
 tb/tb_draw_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// draw_sequencer
//   Frame-level controller for the single VGA plot port. It watches the live
//   board (grid + decoded scores) and a manual redraw request. On any change it
//   freezes a snapshot, optionally sweeps the screen with BG_COLOUR, then
//   releases the board painter from reset and forwards its pixel stream to
//   the VGA adapter for DRAW_CYCLES cycles.
//
//   Optional feature macro: DRAW_SEQ_CLEAR_EN
//     defined     : IDLE -> CLEAR (SCREEN_W x SCREEN_H sweep) -> DRAW -> IDLE
//     not defined : IDLE -> DRAW -> IDLE, no sweep counters or colour mux
//
// Ports
//   clk            system clock
//   resetn         asynchronous active-low reset
//   grid[17:0]     live board state
//   scores[44:0]   live decoded scores {p1, p2, tie}
//   redraw         one-cycle redraw request
//   pix_x/y/colour painter pixel stream
//   grid_snap      frozen grid for the painter
//   scores_snap    frozen scores for the painter
//   painter_resetn painter reset, high only while in DRAW (registered)
//   x_out/y_out/colour_out/plot  VGA adapter write port
//   busy           high whenever not IDLE
//   frame_done     one-cycle pulse in the first IDLE cycle after DRAW
module draw_sequencer #(
  parameter logic [2:0]  BG_COLOUR   = 3'b000,
  parameter int          SCREEN_W    = 160,
  parameter int          SCREEN_H    = 120,
  parameter logic [15:0] DRAW_CYCLES = 16'd7000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [17:0] grid,
  input  logic [44:0] scores,
  input  logic        redraw,
  input  logic [7:0]  pix_x,
  input  logic [6:0]  pix_y,
  input  logic [2:0]  pix_colour,
  output logic [17:0] grid_snap,
  output logic [44:0] scores_snap,
  output logic        painter_resetn,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  colour_out,
  output logic        plot,
  output logic        busy,
  output logic        frame_done
);

  if (DRAW_CYCLES == 16'd0 || SCREEN_W < 1 || SCREEN_W > 256 ||
      SCREEN_H < 1 || SCREEN_H > 128 || $bits(BG_COLOUR) != 3) begin : g_bad_params
    $error("draw_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW
  } state_t;

  localparam logic [15:0] DC_LAST = DRAW_CYCLES - 16'd1;

  state_t      state, state_nx;
  logic        pending;
  logic [15:0] dc;
  logic        change;
  logic        capture;
  logic        draw_last;

`ifdef DRAW_SEQ_CLEAR_EN
  localparam logic [7:0] CX_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] CY_LAST = 7'(SCREEN_H - 1);
  localparam state_t     S_START = S_CLEAR;

  logic [7:0] cx;
  logic [6:0] cy;
  logic       clear_last;

  assign clear_last = (cx == CX_LAST) && (cy == CY_LAST);
`else
  localparam state_t S_START = S_DRAW;
`endif

  assign change    = redraw || (grid != grid_snap) || (scores != scores_snap);
  assign capture   = (state == S_IDLE) && pending;
  assign draw_last = (dc == DC_LAST);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (pending) state_nx = S_START;
`ifdef DRAW_SEQ_CLEAR_EN
      S_CLEAR: if (clear_last) state_nx = S_DRAW;
`endif
      S_DRAW:  if (draw_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output mux is combinational on the state so a reset drops plot at once.
  always_comb begin
    x_out      = '0;
    y_out      = '0;
    colour_out = '0;
    plot       = 1'b0;
    unique case (state)
`ifdef DRAW_SEQ_CLEAR_EN
      S_CLEAR: begin
        x_out      = cx;
        y_out      = cy;
        colour_out = BG_COLOUR;
        plot       = 1'b1;
      end
`endif
      S_DRAW: begin
        x_out      = pix_x;
        y_out      = pix_y;
        colour_out = pix_colour;
        plot       = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  // On the capture edge the snapshot equals the live inputs, so only a
  // concurrent redraw can leave a request pending behind it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      pending        <= 1'b1;
      grid_snap      <= '0;
      scores_snap    <= '0;
      painter_resetn <= 1'b0;
      frame_done     <= 1'b0;
      dc             <= '0;
    end else begin
      state          <= state_nx;
      painter_resetn <= (state_nx == S_DRAW);
      frame_done     <= (state == S_DRAW) && draw_last;
      if (capture) begin
        grid_snap   <= grid;
        scores_snap <= scores;
        pending     <= redraw;
      end else begin
        pending <= pending || change;
      end
      if (state == S_DRAW && !draw_last) dc <= dc + 16'd1;
      else                               dc <= '0;
    end
  end

`ifdef DRAW_SEQ_CLEAR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (state == S_CLEAR) begin
      if (cx == CX_LAST) begin
        cx <= '0;
        cy <= (cy == CY_LAST) ? '0 : cy + 7'd1;
      end else begin
        cx <= cx + 8'd1;
      end
    end else begin
      cx <= '0;
      cy <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_draw_sequencer.sv
module tb_draw_sequencer;

  localparam int          W  = 4;
  localparam int          H  = 2;
  localparam logic [15:0] DC = 16'd5;
`ifdef DRAW_SEQ_CLEAR_EN
  localparam int CLR = W * H;
`else
  localparam int CLR = 0;
`endif
  localparam int L = CLR + int'(DC);

  logic        clk = 1'b0;
  logic        resetn;
  logic [17:0] grid;
  logic [44:0] scores;
  logic        redraw;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [2:0]  pix_colour;
  logic [17:0] grid_snap;
  logic [44:0] scores_snap;
  logic        painter_resetn;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour_out;
  logic        plot;
  logic        busy;
  logic        frame_done;

  draw_sequencer #(
    .BG_COLOUR  (3'b000),
    .SCREEN_W   (W),
    .SCREEN_H   (H),
    .DRAW_CYCLES(DC)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .grid          (grid),
    .scores        (scores),
    .redraw        (redraw),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .pix_colour    (pix_colour),
    .grid_snap     (grid_snap),
    .scores_snap   (scores_snap),
    .painter_resetn(painter_resetn),
    .x_out         (x_out),
    .y_out         (y_out),
    .colour_out    (colour_out),
    .plot          (plot),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a frame is a run of L active cycles, the first CLR of
  // which sweep the screen in raster order, the rest echoing the painter.
  int          m_ph;     // 0 = idle, 1..L = position within the frame
  bit          m_pend;
  logic [17:0] m_gs;
  logic [44:0] m_ss;
  bit          m_fd;
  bit          m_prs;

  function automatic logic [44:0] rnd45();
    return {13'($urandom), $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_pend = 1; m_gs = '0; m_ss = '0; m_fd = 0; m_prs = 0;
  endtask

  task automatic model_edge();
    bit chg;
    if (!resetn) begin
      model_reset();
      return;
    end
    chg  = redraw || (grid != m_gs) || (scores != m_ss);
    m_fd = 0;
    if (m_ph == 0) begin
      if (m_pend) begin
        m_gs   = grid;
        m_ss   = scores;
        m_pend = redraw;
        m_ph   = 1;
      end else begin
        m_pend = chg;
      end
    end else begin
      m_pend = m_pend || chg;
      if (m_ph == L) begin
        m_ph = 0;
        m_fd = 1;
      end else begin
        m_ph++;
      end
    end
    m_prs = (m_ph > CLR);
  endtask

  task automatic check_all();
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    bit         ep;
    ex = '0; ey = '0; ec = '0; ep = 0;
    if (m_ph != 0 && m_ph <= CLR) begin
      ex = 8'((m_ph - 1) % W);
      ey = 7'((m_ph - 1) / W);
      ec = 3'b000;
      ep = 1;
    end else if (m_ph > CLR) begin
      ex = pix_x; ey = pix_y; ec = pix_colour; ep = 1;
    end
    chk("x_out",          64'(x_out),          64'(ex));
    chk("y_out",          64'(y_out),          64'(ey));
    chk("colour_out",     64'(colour_out),     64'(ec));
    chk("plot",           64'(plot),           64'(ep));
    chk("busy",           64'(busy),           64'(m_ph != 0));
    chk("frame_done",     64'(frame_done),     64'(m_fd));
    chk("painter_resetn", 64'(painter_resetn), 64'(m_prs));
    chk("grid_snap",      64'(grid_snap),      64'(m_gs));
    chk("scores_snap",    64'(scores_snap),    64'(m_ss));
  endtask

  task automatic tick();
    pix_x      = 8'($urandom);
    pix_y      = 7'($urandom);
    pix_colour = 3'($urandom);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run_to_idle(input string tag);
    for (int k = 0; k < 4 * L && (m_ph != 0 || m_pend); k++) tick();
    chk(tag, 64'(busy), 64'(0));
  endtask

  int          cnt;
  int          lat;
  logic [44:0] saved_scores;

  initial begin
    resetn = 1'b0; grid = '0; scores = '0; redraw = 1'b0;
    pix_x = '0; pix_y = '0; pix_colour = '0;
    model_reset();
    #2;
    check_all();
    tick(); tick();

    // Reset release: one full frame with no request.
    resetn = 1'b1;
    lat = 0; cnt = 0;
    for (int k = 1; k <= L + 3; k++) begin
      tick();
      if (plot) cnt++;
      if (frame_done && lat == 0) lat = k;
    end
    chk("first_frame_latency", 64'(lat), 64'(L + 1));
    chk("first_frame_plots",   64'(cnt), 64'(L));

    // Idle with stable inputs.
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (plot || busy || frame_done) cnt++;
    end
    chk("idle_activity", 64'(cnt), 64'(0));

    // Grid change in the middle of DRAW.
    redraw = 1'b1; tick(); redraw = 1'b0;
    for (int k = 0; k < 4 * L && m_ph != CLR + 3; k++) tick();
    chk("reach_draw2_busy", 64'(painter_resetn), 64'(1));
    grid = 18'h00001;
    for (int k = 0; k < 4 * L && m_ph != 0; k++) tick();
    chk("old_frame_grid_snap", 64'(grid_snap), 64'(0));
    tick();
    chk("next_frame_grid_snap", 64'(grid_snap), 64'(18'h00001));
    chk("next_frame_busy", 64'(busy), 64'(1));
    run_to_idle("after_mid_draw_change");

    // Redraw while idle keeps the score snapshot.
    saved_scores = rnd45();
    scores = saved_scores;
    run_to_idle("after_score_change");
    for (int k = 0; k < 5; k++) tick();
    redraw = 1'b1; tick(); redraw = 1'b0;
    cnt = 0;
    for (int k = 0; k < L + 3; k++) begin
      tick();
      if (plot) cnt++;
    end
    chk("redraw_frame_plots", 64'(cnt), 64'(L));
    chk("redraw_scores_snap", 64'(scores_snap), 64'(saved_scores));

    // Randomised board activity.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) grid[$urandom_range(0, 17)] ^= 1'b1;
      if ($urandom_range(0, 59) == 0) scores = rnd45();
      redraw = ($urandom_range(0, 29) == 0);
      tick();
    end
    redraw = 1'b0;
    run_to_idle("after_random");

    // Reset three cycles into the frame.
    redraw = 1'b1; tick(); redraw = 1'b0;
    for (int k = 0; k < 4 * L && m_ph != 3; k++) tick();
    resetn = 1'b0;
    #1;
    chk("async_plot_drop",    64'(plot),           64'(0));
    chk("async_prs_drop",     64'(painter_resetn), 64'(0));
    model_reset();
    check_all();
    tick(); tick();
    resetn = 1'b1;
    tick();
    chk("restart_x", 64'(x_out), 64'(CLR > 0 ? 0 : int'(pix_x)));
    chk("restart_y", 64'(y_out), 64'(CLR > 0 ? 0 : int'(pix_y)));
    run_to_idle("after_reset_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
